// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the writeback stage and architectural register file.
//   - Default datapath / register-index widths
//   - MemToReg writeback source encodings
//   - Architecturally significant register indices
package wb_regfile_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;

    // Writeback source select; MTR_RSVD behaves as MTR_ALU.
    typedef enum logic [1:0] {
        MTR_ALU  = 2'b00,
        MTR_MEM  = 2'b01,
        MTR_LINK = 2'b10,
        MTR_RSVD = 2'b11
    } mem_to_reg_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB pipeline register / ID stage and wb_regfile.
//   master: drives WB_* controls/data and ReadRegister1/2,
//           receives ReadData1/2, WB_WriteData, WB_WriteEn
//   slave : the register file (opposite directions)
interface wb_regfile_if
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);

    logic              WB_RegWrite;
    logic [1:0]        WB_MemToReg;
    logic              WB_halfbyte;
    logic              WB_jr;
    logic [DATA_W-1:0] WB_PCAddResult;
    logic [DATA_W-1:0] WB_Read;
    logic [DATA_W-1:0] WB_ALUResult;
    logic [ADDR_W-1:0] WB_RegDst;
    logic [ADDR_W-1:0] ReadRegister1;
    logic [ADDR_W-1:0] ReadRegister2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic [DATA_W-1:0] WB_WriteData;
    logic              WB_WriteEn;

    modport master (
        output WB_RegWrite, WB_MemToReg, WB_halfbyte, WB_jr,
        output WB_PCAddResult, WB_Read, WB_ALUResult, WB_RegDst,
        output ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2, WB_WriteData, WB_WriteEn
    );

    modport slave (
        input  WB_RegWrite, WB_MemToReg, WB_halfbyte, WB_jr,
        input  WB_PCAddResult, WB_Read, WB_ALUResult, WB_RegDst,
        input  ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2, WB_WriteData, WB_WriteEn
    );

endinterface

// File: rtl/wb_data_mux.sv
// Writeback source select.
//   mem_to_reg  in  2       source select (ALU / load / link, 11 = ALU)
//   halfbyte    in  1       load is a halfword: sign-extend bits [15:0]
//   pc_add      in  DATA_W  PC+4 link value
//   read_data   in  DATA_W  data-memory load result
//   alu_result  in  DATA_W  ALU result
//   write_data  out DATA_W  selected writeback value
module wb_data_mux
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [1:0]        mem_to_reg,
    input  logic              halfbyte,
    input  logic [DATA_W-1:0] pc_add,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] write_data
);

    always_comb begin
        write_data = alu_result;
        case (mem_to_reg_e'(mem_to_reg))
            MTR_MEM: begin
                if (halfbyte) begin
                    write_data = {{(DATA_W-16){read_data[15]}}, read_data[15:0]};
                end else begin
                    write_data = read_data;
                end
            end
            MTR_LINK: write_data = pc_add;
            default:  write_data = alu_result;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus 2^ADDR_W x DATA_W architectural register file.
//   Clk    in  1   pipeline clock, rising edge
//   Reset  in  1   asynchronous active-low reset; clears every register
//   bus    slave   MEM/WB writeback inputs, two ID-stage read ports with
//                  same-cycle write-through bypass, WB_WriteData/WB_WriteEn
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic         Clk,
    input  logic         Reset,
    wb_regfile_if.slave  bus
);

    localparam int unsigned NUM_REGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] write_data;
    logic              write_en;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;

    wb_data_mux #(.DATA_W(DATA_W)) u_data_mux (
        .mem_to_reg (bus.WB_MemToReg),
        .halfbyte   (bus.WB_halfbyte),
        .pc_add     (bus.WB_PCAddResult),
        .read_data  (bus.WB_Read),
        .alu_result (bus.WB_ALUResult),
        .write_data (write_data)
    );

    // Gating with Reset keeps the bypass path quiet while reset is held.
    assign write_en = Reset & bus.WB_RegWrite & ~bus.WB_jr
                    & (bus.WB_RegDst != ZERO_IDX);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[bus.WB_RegDst] <= write_data;
        end
    end

    // Reads under reset return 0 without extra gating: the array is
    // already clear and write_en is low, so the bypass cannot fire.
    always_comb begin
        if (bus.ReadRegister1 == ZERO_IDX) begin
            read_data1 = '0;
        end else if (write_en && (bus.WB_RegDst == bus.ReadRegister1)) begin
            read_data1 = write_data;
        end else begin
            read_data1 = regs[bus.ReadRegister1];
        end
    end

    always_comb begin
        if (bus.ReadRegister2 == ZERO_IDX) begin
            read_data2 = '0;
        end else if (write_en && (bus.WB_RegDst == bus.ReadRegister2)) begin
            read_data2 = write_data;
        end else begin
            read_data2 = regs[bus.ReadRegister2];
        end
    end

    assign bus.ReadData1    = read_data1;
    assign bus.ReadData2    = read_data2;
    assign bus.WB_WriteData = write_data;
    assign bus.WB_WriteEn   = write_en;

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage plus architectural register file for the 5-stage MIPS pipeline. It consumes the MEM/WB pipeline register outputs, selects the writeback value (ALU result, load data or link address), and commits it to a 32×32 register file on the rising clock edge. It provides two combinational read ports to the ID stage, with same-cycle write-through bypass, so the decode stage never reads a stale value.

## Interface
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register index width (2^ADDR_W registers)

- Clk  in  1  pipeline clock, rising edge
- Reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- WB_RegWrite  in  1  write enable from MEM/WB
- WB_MemToReg  in  2  writeback source select
- WB_halfbyte  in  1  load data is a halfword; sign-extend bits [15:0]
- WB_jr  in  1  jr instruction in WB; suppresses the write
- WB_PCAddResult  in  DATA_W  PC+4 of the WB instruction (link value)
- WB_Read  in  DATA_W  data-memory load result
- WB_ALUResult  in  DATA_W  ALU result
- WB_RegDst  in  ADDR_W  destination register index
- ReadRegister1, ReadRegister2  in  ADDR_W  ID-stage source indices
- ReadData1, ReadData2  out  DATA_W  ID-stage source values
- WB_WriteData  out  DATA_W  selected writeback value, for forwarding and debug
- WB_WriteEn  out  1  qualified write strobe, for forwarding and debug

## Operation
- Source select, based on WB_MemToReg:
  - 2'b00: WB_ALUResult.
  - 2'b01: load data. If WB_halfbyte=1, use {{16{WB_Read[15]}}, WB_Read[15:0]}; otherwise use WB_Read.
  - 2'b10: WB_PCAddResult (jal link).
  - 2'b11: reserved; treated as 2'b00.
- WB_halfbyte is ignored unless WB_MemToReg=2'b01.
- WB_WriteEn = Reset & WB_RegWrite & ~WB_jr & (WB_RegDst != 0).
- Register 0 is hardwired to 0. Writes to it are dropped and reads of it return 0.
- Read port n returns the first matching case:
  - 0 if ReadRegistern = 0;
  - WB_WriteData if WB_WriteEn and WB_RegDst = ReadRegistern (bypass);
  - otherwise the stored register value.
- Both ports may read the same register. Both then see identical data, including the bypass.

## Timing
- Write: committed on the rising edge of Clk when WB_WriteEn=1; visible from the array on the next cycle.
- Read: purely combinational. Bypass makes a same-cycle write visible with zero-cycle latency.
- Reset asserted (Reset=0): all 32 registers clear to 0 immediately, without waiting for a clock edge.
  - While reset is held, ReadData1/2 = 0, WB_WriteEn = 0, and no write occurs.
  - WB_WriteData stays combinational; it is not gated by reset.
- Reset deasserted between edges: the first write is taken on the next rising edge.
- Reset asserted mid-cycle during a pending write: the write is lost and the register reads 0.
- Simultaneous write to R and read of R: the read returns the new value.
- Write with WB_jr=1 or WB_RegWrite=0: the array is unchanged and there is no bypass.

## Structure
- Shared package holds:
  - MemToReg encodings: MTR_ALU=2'b00, MTR_MEM=2'b01, MTR_LINK=2'b10.
  - REG_ZERO=0 and REG_RA=31.
  - DATA_W and ADDR_W defaults.
- Sub-module wb_data_mux: combinational source select and halfword sign-extension, producing WB_WriteData.
- The top level holds the register array, the write logic and the two bypassed read ports.

## Test plan
- Reset: hold Reset=0 after arbitrary writes -> every register reads 0; release it, write R5=0x1234 -> R5 reads 0x1234 on the next cycle.
- Source select: MemToReg=00, ALU=0xA5A5A5A5 -> R8=0xA5A5A5A5. MemToReg=01, halfbyte=1, Read=0x0000F00D -> R9=0xFFFFF00D. MemToReg=10, PC+4=0x40 -> R31=0x40.
- Bypass: in the same cycle, write R10=0xDEADBEEF with ReadRegister1=ReadRegister2=10 -> both ports show 0xDEADBEEF before the edge.
- Zero register: RegWrite=1, RegDst=0, ALU=0xFFFFFFFF -> WB_WriteEn=0 and R0 reads 0 on both ports.
- Suppression: RegWrite=1, jr=1, RegDst=4 -> R4 keeps its prior value and there is no bypass; repeat with RegWrite=0 -> same result.
- Reset mid-operation: assert Reset=0 between edges while a write to R3 is pending -> R3=0, and ReadData goes to 0 immediately.
